// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-fetch slice: fetch FSM states,
// queue entry layout and the PC wrap helper.
package imem_pkg;

  localparam int ADDR_W = 8;
  localparam int unsigned MEM_DEPTH_DEF = 64;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;
  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [7:0]        data;
  } fetch_entry_t;

  // Only the implemented memory words are addressable, so every PC update wraps.
  function automatic logic [ADDR_W-1:0] pc_mod(input logic [ADDR_W-1:0] a,
                                               input int unsigned depth);
    int unsigned r;
    r = 32'(a) % depth;
    return ADDR_W'(r);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue2.sv
// fetch_queue2: two-entry {pc, byte} FIFO between the memory return path and
// decode. Flush wins over push/pop; storage resets to zero so the head never reads X.
module fetch_queue2
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC, in-flight read tracking and IDLE/RUN/HALTED FSM in front of
// a 1-cycle synchronous instruction memory. FETCH_PERF_EN adds fetch/stall counters.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr/instr_pc are stable while instr_valid is high
// and instr_ready is low.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [7:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted,
  output fetch_state_e      dbg_state_o
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              pending_q;
  logic              busy_q, halted_q;

  logic              pop, push, halt_push, issue;
  logic [1:0]        q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_in;

  always_comb begin
    pop       = (q_count != 2'd0) && instr_ready;
    push      = pending_q && !redirect_valid;
    halt_push = push && (imem_data == HALT_OPCODE);
    // Queue slots already spoken for (stored + in flight) must stay <= 2; a pop this
    // edge frees one. Nothing issues on the edge the halt byte lands.
    issue     = (state_q == ST_RUN) && !redirect_valid && !halt_push &&
                ((({1'b0, q_count} + {2'b00, pending_q}) < 3'd2) || pop);
    q_in.pc   = pend_pc_q;
    q_in.data = imem_data;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:   if (start)     state_d = ST_RUN;
        ST_RUN:    if (halt_push) state_d = ST_HALTED;
        ST_HALTED: if (start)     state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALTED);
      if (redirect_valid) begin
        pc_q      <= pc_mod(redirect_pc, MEM_DEPTH);
        pending_q <= 1'b0;
      end else begin
        pending_q <= issue;
        if (issue) begin
          pend_pc_q <= pc_q;
          pc_q      <= pc_mod(pc_q + ADDR_W'(1), MEM_DEPTH);
        end
      end
    end
  end

  fetch_queue2 u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (q_in),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (q_head),
    .count_o      (q_count)
  );

  assign imem_addr   = pc_q;
  assign instr       = q_head.data;
  assign instr_pc    = q_head.pc;
  assign instr_valid = (q_count != 2'd0);
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetched_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else if (redirect_valid) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && (fetched_q != 16'hFFFF)) fetched_q <= fetched_q + 16'd1;
      if (instr_valid && !instr_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: models the 64x8 synchronous memory and walks
// through start latency, backpressure, wrap, redirect flush, halt and async reset.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_data;
  logic [7:0]  instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        halted;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  logic [7:0] mem [64];
  int n_cmp  = 0;
  int n_fail = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .halted         (halted),
    .dbg_state_o    (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial imem_data = 8'h00;
  always @(posedge clk) imem_data <= mem[imem_addr[5:0]];

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] d, input logic [7:0] pc);
    chk1({tag, ".valid"}, instr_valid, 1'b1);
    chk8({tag, ".instr"}, instr, d);
    chk8({tag, ".pc"}, instr_pc, pc);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk1({tag, ".valid"}, instr_valid, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".halted"}, halted, 1'b0);
    chk8({tag, ".addr"}, imem_addr, 8'h00);
    chk8({tag, ".instr"}, instr, 8'h00);
    chk8({tag, ".instr_pc"}, instr_pc, 8'h00);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h50 + 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    // reset state
    tick(); tick();
    chk_reset_outs("rst");
    chk8("rst.state", 8'(dbg_state), 8'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    chk1("idle.busy", busy, 1'b0);

    // start latency and streaming
    start = 1'b1; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk1("s0.busy", busy, 1'b1);
    chk1("s0.valid", instr_valid, 1'b0);
    tick();
    chk1("s1.valid", instr_valid, 1'b0);
    chk8("s1.addr", imem_addr, 8'd1);
    tick(); chk_instr("s2", 8'h11, 8'd0);
    tick(); chk_instr("s3", 8'h22, 8'd1);
    tick(); chk_instr("s4", 8'h33, 8'd2);
    tick(); chk_instr("s5", 8'h44, 8'd3);
    tick(); chk_instr("s6", 8'h54, 8'd4);

    // backpressure: queue fills with PCs 4,5, issue stops at PC 6
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_instr("bp.hold", 8'h54, 8'd4);
      chk8("bp.addr", imem_addr, 8'd6);
    end
    instr_ready = 1'b1;
    tick(); chk_instr("bp.r0", 8'h55, 8'd5);
    tick(); chk_instr("bp.r1", 8'h56, 8'd6);
    tick(); chk_instr("bp.r2", 8'h57, 8'd7);

    // wrap: redirect to 62 while a read is pending
    mem[62] = 8'hA1; mem[63] = 8'hA2; mem[0] = 8'hA3;
    redirect_valid = 1'b1; redirect_pc = 8'd62;
    tick();
    redirect_valid = 1'b0;
    chk1("w0.valid", instr_valid, 1'b0);
    chk8("w0.addr", imem_addr, 8'd62);
    tick();
    chk1("w1.valid", instr_valid, 1'b0);
    chk8("w1.addr", imem_addr, 8'd63);
    tick(); chk_instr("w2", 8'hA1, 8'd62);
    chk8("w2.addr", imem_addr, 8'd0);
    tick(); chk_instr("w3", 8'hA2, 8'd63);
    tick(); chk_instr("w4", 8'hA3, 8'd0);
    tick(); chk_instr("w5", 8'h22, 8'd1);

    // redirect with full queue: head (22,1) is consumed on the redirect edge, (33,2) never shown
    instr_ready = 1'b0;
    tick(); chk_instr("f.fill", 8'h22, 8'd1);
    tick(); chk_instr("f.full", 8'h22, 8'd1);
    chk8("f.addr", imem_addr, 8'd3);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd10;
    tick();
    redirect_valid = 1'b0;
    chk1("f0.valid", instr_valid, 1'b0);
    chk8("f0.addr", imem_addr, 8'd10);
    tick();
    chk1("f1.valid", instr_valid, 1'b0);
    tick(); chk_instr("f2", 8'h5A, 8'd10);
    tick(); chk_instr("f3", 8'h5B, 8'd11);

    // halt at PC 5
    mem[5] = 8'hFF;
    redirect_valid = 1'b1; redirect_pc = 8'd3;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick(); chk_instr("h2", 8'h44, 8'd3);
    tick(); chk_instr("h3", 8'h54, 8'd4);
    tick(); chk_instr("h4", 8'hFF, 8'd5);
    chk1("h4.halted", halted, 1'b1);
    chk1("h4.busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("h.novalid", instr_valid, 1'b0);
      chk8("h.addr", imem_addr, 8'd6);
    end
    // 0x40 wraps to PC 0
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk1("hr0.busy", busy, 1'b1);
    chk1("hr0.halted", halted, 1'b0);
    chk8("hr0.addr", imem_addr, 8'd0);
    tick();
    tick(); chk_instr("hr2", 8'hA3, 8'd0);
    tick(); chk_instr("hr3", 8'h22, 8'd1);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    #2;
    rst_n = 1'b1;
    tick();
    chk1("post.valid", instr_valid, 1'b0);
    chk1("post.busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk1("post1.valid", instr_valid, 1'b0);
    tick(); chk_instr("post2", 8'hA3, 8'd0);
    tick(); chk_instr("post3", 8'h22, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the 64 x 8-bit synchronous-read instruction memory (1-cycle registered read, no enable).
- Owns the program counter and drives the memory address.
- Tracks the in-flight read and buffers returned bytes in a 2-entry output queue.
- Presents instructions to the decode stage over a valid/ready handshake; supports redirect (branch/jump) and a halt opcode.

Parameters:
ADDR_W, 8, instruction address width (matches memory address port)
MEM_DEPTH, 64, number of implemented memory words; PC wraps modulo this
RESET_PC, 8'h00, PC value after reset
HALT_OPCODE, 8'hFF, instruction byte that stops fetching

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; in IDLE begins fetching at current PC
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  8  redirect target
imem_addr  out  8  address to instruction memory (= PC register)
imem_data  in  8  data from instruction memory, valid the cycle after its address was sampled
instr  out  8  head-of-queue instruction
instr_pc  out  8  address of instr
instr_valid  out  1  queue non-empty
instr_ready  in  1  decode accepts instr
busy  out  1  state is RUN
halted  out  1  state is HALTED

Behaviour:
- Reset (async, rst_n=0): state IDLE, PC=RESET_PC, imem_addr=RESET_PC, queue empty, pending=0, instr=0, instr_pc=0, instr_valid=0, busy=0, halted=0. Any in-flight read is discarded.
- States:
  - IDLE -> RUN on start or redirect_valid.
  - RUN -> HALTED when a byte equal to HALT_OPCODE is written into the queue.
  - HALTED -> RUN on redirect_valid or start.
- No state returns to IDLE except via reset.
- Issue:
  - Only in RUN, and only when (count + pending) < 2 or (instr_valid && instr_ready).
  - At the issuing edge: pending<=1, pend_pc<=PC, PC<=(PC+1) mod MEM_DEPTH (63 -> 0).
  - A non-issuing edge in RUN/IDLE/HALTED sets pending<=0.
- Return: if pending=1 (and not squashed), imem_data is written into the queue tail with pend_pc at the next edge.
- Latency: start sampled at edge E -> address issued at E+1 -> queue write at E+2 -> instr_valid=1 after E+2.
- Throughput: one instruction per cycle while instr_ready stays high.
- Queue: 2-entry FIFO of {pc, byte}.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle is allowed; count unchanged.
  - The issue rule guarantees no overflow; an overflow condition is a design error.
- Halt:
  - The halt byte itself is queued and delivered like any instruction.
  - No further issues after it is written.
  - A read already pending at that edge is squashed.
- Redirect (any state):
  - Queue cleared, pending squashed, PC<=redirect_pc mod MEM_DEPTH.
  - State becomes RUN; issue resumes at the following edge.
  - A pop in the same cycle as redirect completes (the consumer took it); everything else is flushed.
  - Redirect has priority over start and over halt detection in the same cycle.
- start in RUN is ignored. start and redirect in IDLE together: redirect target used.
- instr/instr_pc hold the head entry; when empty they hold last value (don't-care, but must not X after reset).

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched[15:0] (count of queue writes) and perf_stall[15:0] (cycles with instr_valid=1 and instr_ready=0).
  - Both counters saturate at 16'hFFFF.
  - Both clear on reset and on redirect_valid.
- Undefined: these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Shared package imem_pkg:
  - fetch state enum (IDLE, RUN, HALTED)
  - ADDR_W
  - MEM_DEPTH default
  - HALT_OPCODE default
  - fetch entry struct {pc[7:0], data[7:0]}
- One natural sub-module: fetch_queue2 (2-entry FIFO with push, pop, flush, count). PC, pending logic and the FSM stay in the top.

Test Plan:
- Reset then start with instr_ready=1, memory[0..3]=11,22,33,44:
  - instr_valid rises 2 cycles after start.
  - instr/instr_pc stream (11,0),(22,1),(33,2),(44,3) on consecutive cycles.
- Backpressure: instr_ready=0 for 5 cycles mid-stream:
  - count reaches 2 and issue stops.
  - After ready returns, no byte is lost or duplicated and the PCs stay in order.
- Wrap: redirect to 62 with memory[62]=A1, [63]=A2, [0]=A3 -> delivered PCs 62, 63, 0.
- Redirect with queue full and a read pending, target 10:
  - Queued and pending entries are never presented.
  - Next delivered entry is (mem[10],10).
  - A same-cycle pop completes.
- Halt: memory[5]=FF:
  - (FF,5) is delivered, halted=1, busy=0, no further instr_valid.
  - Redirect to 0 resumes from PC 0.
- Async reset asserted mid-stream between clock edges: all outputs go to reset values immediately. After release and start, fetch restarts at RESET_PC.
